// File: rtl/sobel_pkg.sv
// Shared constants and window packing helper for the 5x5 Sobel/Laplace path.
// The MPU and kernel constants use the same win_idx() so byte ordering cannot diverge.
package sobel_pkg;

  localparam int PIXEL_W      = 8;
  localparam int WIN_N        = 5;
  localparam int MATRIX_5x5_W = PIXEL_W * WIN_N * WIN_N;
  localparam int LINE_W       = PIXEL_W * (WIN_N - 1);

  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic int win_idx(input int r, input int c);
    return r * WIN_N + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Line buffer: one entry per image column holding the four previous rows at that column.
// Asynchronous read, synchronous write, contents are never reset.
module line_buffer_ram #(
  parameter int DEPTH  = 320,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  assign rd_data = mem_reg[addr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_5x5_builder.sv
// Builds packed 5x5 windows from a raster pixel stream for the 5x5 convolution MPU.
// Optional WINDOW_STATUS_EN adds window_x/window_y centre coordinates and a frame_done pulse.
module window_5x5_builder
  import sobel_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [PIXEL_W-1:0]      pixel_data,
  input  logic                    pixel_first,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  output logic [MATRIX_5x5_W-1:0] window,
  output logic                    window_valid,
  input  logic                    window_ready
`ifdef WINDOW_STATUS_EN
  ,
  output logic [15:0]             window_x,
  output logic [15:0]             window_y,
  output logic                    frame_done
`endif
);

  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(WIN_N - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(WIN_N - 1);

  logic [COL_W-1:0]        col_reg, col_next, pos_col;
  logic [ROW_W-1:0]        row_reg, row_next, pos_row;
  logic                    accept;
  logic                    emit;
  logic                    frame_end;
  logic [LINE_W-1:0]       line_rd;
  logic [LINE_W-1:0]       line_wr;
  logic [MATRIX_5x5_W-1:0] window_reg, window_next, shifted;
  logic                    window_valid_reg, window_valid_next;
  pixel_t                  col_in [WIN_N];

  assign pixel_ready = !window_valid_reg || window_ready;
  assign accept      = pixel_valid && pixel_ready;

  // pixel_first forces the accepted pixel to (0,0) regardless of stale counters
  assign pos_col   = pixel_first ? '0 : col_reg;
  assign pos_row   = pixel_first ? '0 : row_reg;
  assign emit      = (pos_col >= COL_EDGE) && (pos_row >= ROW_EDGE);
  assign frame_end = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

  assign line_wr = {line_rd[LINE_W-PIXEL_W-1:0], pixel_data};

  line_buffer_ram #(
    .DEPTH  (IMAGE_WIDTH),
    .DATA_W (LINE_W),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (pos_col),
    .wr_data (line_wr),
    .rd_data (line_rd)
  );

  // Shift every row one column left; the new right column is the buffered column plus the live pixel.
  genvar gi, gj;
  generate
    for (gi = 0; gi < WIN_N; gi++) begin : g_row
      if (gi < WIN_N - 1) begin : g_buf
        assign col_in[gi] = line_rd[(WIN_N-2-gi)*PIXEL_W +: PIXEL_W];
      end else begin : g_live
        assign col_in[gi] = pixel_data;
      end
      for (gj = 0; gj < WIN_N - 1; gj++) begin : g_col
        assign shifted[win_idx(gi, gj)*PIXEL_W +: PIXEL_W] =
          window_reg[win_idx(gi, gj + 1)*PIXEL_W +: PIXEL_W];
      end
      assign shifted[win_idx(gi, WIN_N-1)*PIXEL_W +: PIXEL_W] = col_in[gi];
    end
  endgenerate

  always_comb begin
    col_next          = col_reg;
    row_next          = row_reg;
    window_next       = window_reg;
    window_valid_next = window_valid_reg;
    if (accept) begin
      window_next = shifted;
      if (pos_col == COL_LAST) begin
        col_next = '0;
        row_next = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_next = pos_col + COL_W'(1);
        row_next = pos_row;
      end
    end
    if (accept && emit) begin
      window_valid_next = 1'b1;
    end else if (window_ready) begin
      window_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_reg          <= '0;
      row_reg          <= '0;
      window_reg       <= '0;
      window_valid_reg <= 1'b0;
    end else begin
      col_reg          <= col_next;
      row_reg          <= row_next;
      window_reg       <= window_next;
      window_valid_reg <= window_valid_next;
    end
  end

  assign window       = window_reg;
  assign window_valid = window_valid_reg;

`ifdef WINDOW_STATUS_EN
  logic [15:0] window_x_reg, window_y_reg;
  logic        frame_done_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      window_x_reg   <= '0;
      window_y_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= accept && frame_end;
      if (accept && emit) begin
        window_x_reg <= 16'(pos_col) - 16'd2;
        window_y_reg <= 16'(pos_row) - 16'd2;
      end
    end
  end

  assign window_x   = window_x_reg;
  assign window_y   = window_y_reg;
  assign frame_done = frame_done_reg;
`else
  logic unused_status;
  assign unused_status = frame_end;
`endif

endmodule

// File: tb/tb_window_5x5_builder.sv
// Randomized self-checking bench for window_5x5_builder on an 8x6 image.
// The reference keeps the frame as a 2D array and cuts the expected 5x5 window from it.
module tb_window_5x5_builder;

  localparam int W = 8;
  localparam int H = 6;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   pixel_data = '0;
  logic         pixel_first = 1'b0;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready;
  logic [199:0] window;
  logic         window_valid;
  logic         window_ready = 1'b1;
`ifdef WINDOW_STATUS_EN
  logic [15:0]  window_x, window_y;
  logic         frame_done;
`endif

  always #5 clock = ~clock;

  window_5x5_builder #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pixel_data   (pixel_data),
    .pixel_first  (pixel_first),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window       (window),
    .window_valid (window_valid),
    .window_ready (window_ready)
`ifdef WINDOW_STATUS_EN
    ,
    .window_x     (window_x),
    .window_y     (window_y),
    .frame_done   (frame_done)
`endif
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [199:0] win;
    int           x;
    int           y;
  } exp_t;

  exp_t         exp_q[$];
  logic [199:0] obs_q[$];
  logic [199:0] cont_q[$];
  logic [7:0]   img [H][W];
  int           m_col = 0;
  int           m_row = 0;
  int           cyc = 0;
  int           end_cyc = -10;

  always @(posedge clock) cyc++;

  task automatic model_accept(input logic [7:0] pix, input logic first, output bit emits);
    int c;
    int r;
    exp_t e;
    c = first ? 0 : m_col;
    r = first ? 0 : m_row;
    img[r][c] = pix;
    emits = 1'b0;
    if (r >= 4 && c >= 4) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          e.win[(i*5+j)*8 +: 8] = img[r-4+i][c-4+j];
      e.x = c - 2;
      e.y = r - 2;
      exp_q.push_back(e);
      emits = 1'b1;
    end
    if (c == W-1 && r == H-1) end_cyc = cyc + 1;
    if (c == W-1) begin
      m_col = 0;
      m_row = (r == H-1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] pix, input logic first);
    bit emits;
    bit done;
    int waitn;
    emits = 1'b0;
    done  = 1'b0;
    waitn = 0;
    pixel_data  = pix;
    pixel_first = first;
    pixel_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (pixel_ready) begin
        model_accept(pix, first, emits);
        done = 1'b1;
      end else if (++waitn > 100) begin
        check("accept_timeout", 256'(0), 256'(1));
        done = 1'b1;
      end
    end
    @(posedge clock); #1;
    pixel_valid = 1'b0;
    pixel_first = 1'b0;
    if (emits) check("win_latency", 256'(window_valid), 256'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_frame(input int kind, input int gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps != 0 && $urandom_range(0, 1) == 1) idle(1);
        send((kind == 0) ? 8'(r*16 + c) : 8'($urandom), 1'(r == 0 && c == 0));
      end
  endtask

  // ---------------- downstream ready control ----------------
  int           rdy_mode = 0;
  int           bp_cnt = 0;
  bit           bp_done = 1'b0;
  logic [199:0] bp_hold = '0;

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      1: if (!bp_done) begin
           if (bp_cnt == 0 && window_valid) begin
             window_ready = 1'b0;
             bp_cnt       = 5;
             bp_hold      = window;
           end else if (bp_cnt > 0) begin
             bp_cnt--;
             if (bp_cnt == 0) begin
               window_ready = 1'b1;
               bp_done      = 1'b1;
             end
           end
         end
      2: window_ready = ($urandom_range(0, 2) != 0);
      default: window_ready = 1'b1;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;

  always @(negedge clock) begin
    if (reset_n && window_valid && window_ready) begin
      obs_q.push_back(window);
      if (exp_q.size() == 0) begin
        check("unexpected_window", 256'(window_valid), 256'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("window", 256'(window), 256'(mon_e.win));
`ifdef WINDOW_STATUS_EN
        check("window_x", 256'(window_x), 256'(mon_e.x));
        check("window_y", 256'(window_y), 256'(mon_e.y));
`endif
      end
    end
    if (rdy_mode == 1 && !window_ready) begin
      check("bp_stable", 256'(window), 256'(bp_hold));
      check("bp_pixel_ready", 256'(pixel_ready), 256'(0));
      check("bp_valid", 256'(window_valid), 256'(1));
    end
`ifdef WINDOW_STATUS_EN
    if (reset_n) check("frame_done", 256'(frame_done), 256'(cyc == end_cyc));
`endif
  end

  // ---------------- stimulus ----------------
  logic [199:0] w;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 256'(window_valid), 256'(0));
    check("rst_window", 256'(window), 256'(0));
    check("rst_pixel_ready", 256'(pixel_ready), 256'(1));
    reset_n = 1'b1;
    idle(1);

    // continuous full frame, pixel = row*16+col
    obs_q.delete();
    send_frame(0, 0);
    idle(3);
    check("a_count", 256'(obs_q.size()), 256'(8));
    check("a_pending", 256'(exp_q.size()), 256'(0));
    w = obs_q[0];
    check("a_first_b0", 256'(w[0*8 +: 8]), 256'(8'h00));
    check("a_first_b12", 256'(w[12*8 +: 8]), 256'(8'h22));
    check("a_first_b24", 256'(w[24*8 +: 8]), 256'(8'h44));
    w = obs_q[obs_q.size()-1];
    check("a_last_b12", 256'(w[12*8 +: 8]), 256'(8'h35));
    cont_q = obs_q;

    // back-pressure for 5 cycles on the first window
    obs_q.delete();
    rdy_mode = 1;
    send_frame(0, 0);
    idle(3);
    rdy_mode = 0;
    idle(1);
    check("b_bp_done", 256'(bp_done), 256'(1));
    check("b_hold_b24", 256'(bp_hold[24*8 +: 8]), 256'(8'h44));
    check("b_count", 256'(obs_q.size()), 256'(8));
    w = obs_q[1];
    check("b_next_b24", 256'(w[24*8 +: 8]), 256'(8'h45));

    // reset after 20 pixels, then a fresh random frame
    for (int k = 0; k < 20; k++) send(8'(k), 1'(k == 0));
    reset_n = 1'b0;
    idle(1);
    check("c_rst_valid", 256'(window_valid), 256'(0));
    reset_n = 1'b1;
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    obs_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send(8'($urandom), 1'b0);
    idle(3);
    check("c_count", 256'(obs_q.size()), 256'(8));
    check("c_pending", 256'(exp_q.size()), 256'(0));

    // stop at stale position (3,2), then resync with pixel_first
    for (int k = 0; k < 2*W + 3; k++) send(8'($urandom), 1'(k == 0));
    obs_q.delete();
    send_frame(1, 0);
    idle(3);
    check("d_count", 256'(obs_q.size()), 256'(8));
    check("d_pending", 256'(exp_q.size()), 256'(0));

    // random valid gaps: same windows as the continuous run
    obs_q.delete();
    send_frame(0, 1);
    idle(3);
    check("e_count", 256'(obs_q.size()), 256'(8));
    for (int i = 0; i < 8; i++) check($sformatf("e_seq%0d", i), 256'(obs_q[i]), 256'(cont_q[i]));

    // random gaps and random downstream ready, random pixels
    obs_q.delete();
    rdy_mode = 2;
    send_frame(1, 1);
    send_frame(1, 1);
    rdy_mode = 0;
    idle(4);
    check("f_count", 256'(obs_q.size()), 256'(16));
    check("f_pending", 256'(exp_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/window_5x5_builder.md
Name: window_5x5_builder

Overview:
- Upstream feeder for the 5x5 convolution MPU (Laplace/Sobel path).
- Takes a raster-order 8-bit grayscale pixel stream. Buffers four previous image rows and a 5x5 shift window.
- Emits one packed 200-bit window per valid (non-border) pixel position, ready to drive the MPU `matrix` input with the same byte ordering as the kernel.

Parameters:
- IMAGE_WIDTH, 320, pixels per row; legal range ≥5.
- IMAGE_HEIGHT, 240, rows per frame; legal range ≥5.

Ports:
- clock  in  1  single clock; rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pixel_data  in  8  unsigned grayscale pixel.
- pixel_first  in  1  marks first pixel of a frame; qualified by pixel_valid.
- pixel_valid  in  1  pixel_data valid.
- pixel_ready  out  1  block can accept a pixel this cycle.
- window  out  200  packed 5x5 window; byte i at [i*8 +: 8], i = r*5+c; r=0 top (oldest) row, c=0 leftmost (oldest) column.
- window_valid  out  1  window holds an unconsumed window.
- window_ready  in  1  downstream accepts window this cycle.

Behaviour:
- Accept: pixel_valid && pixel_ready. Nothing changes on cycles without an accept, except window_valid clearing.
- pixel_ready = !window_valid || window_ready. This is combinational and gives zero-bubble streaming.
- Counters col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) give the position of the pixel being accepted.
  - col increments per accept and wraps to 0 with row+1.
  - At (W-1, H-1), both counters wrap to (0,0).
  - An accept with pixel_first=1 is treated as position (0,0), whatever the counter values. The counters then continue from (1,0) (or (0,1) if W=1, which is illegal anyway).
- Line buffer: depth IMAGE_WIDTH, 32-bit entries = {row-4, row-3, row-2, row-1} bytes at column col.
  - On accept: read entry[col] (asynchronous read). Write entry[col] <= {row-3, row-2, row-1, pixel_data}.
- Window shift on accept:
  - All columns shift left (c → c-1).
  - New column c=4 = {entry[col] bytes as rows 0..3, pixel_data as row 4}.
- Window emission: if the accepted pixel has row ≥ 4 and col ≥ 4, window_valid = 1 on the next cycle. The window then holds rows row-4..row and columns col-4..col, centred at (row-2, col-2).
- Latency: 1 clock from the accepting edge to window_valid.
- Per frame: exactly (IMAGE_WIDTH-4)*(IMAGE_HEIGHT-4) windows.
- window_valid rules:
  - Clears when window_ready=1 and the same cycle's accept does not produce a new window.
  - If the same cycle's accept does produce a new window, window_valid stays 1 and window takes the new data.
  - With window_valid=1 and window_ready=0: window is stable and pixel_ready=0.
- Border pixels (row<4 or col<4) update the line buffer and shift register but never raise window_valid. Stale data across row/frame boundaries is therefore never emitted.
- Reset (reset_n=0 at a clock edge), including mid-frame:
  - col=0, row=0, window_valid=0, window=0, optional status outputs 0.
  - Line buffer contents are not reset and are unobservable until overwritten.
  - The first pixel after reset is position (0,0).
- All values unsigned 8-bit. No arithmetic beyond counter increments and compares.

Optional Feature:
- Macro WINDOW_STATUS_EN.
- Defined: adds outputs window_x (16 bits) and window_y (16 bits), the centre coordinates (col-2, row-2), registered with window and held while window_valid. Also adds frame_done (1 bit), a one-cycle pulse on the cycle after the accept of pixel (W-1, H-1).
- Undefined: these ports and their registers do not exist; core behaviour is identical.

Decomposition:
- Shared package sobel_pkg:
  - PIXEL_W=8, WIN_N=5.
  - MATRIX_5x5_W=200.
  - Function win_idx(r,c)=r*5+c. Shared with the MPU and kernel constants so packing cannot diverge.
- Sub-module line_buffer_ram: IMAGE_WIDTH x 32, asynchronous read, synchronous write, no reset.

Test Plan (IMAGE_WIDTH=8, IMAGE_HEIGHT=6, pixel value = row*16+col, window_ready=1 unless stated):
- Full frame streamed continuously:
  - Exactly 8 windows.
  - First window_valid one cycle after accepting pixel (4,4), with window byte0=0x00, byte12=0x22, byte24=0x44.
  - Last window centre byte12=0x35.
- Back-pressure: window_ready=0 for 5 cycles after the first window:
  - window stable at byte24=0x44.
  - pixel_ready=0 throughout.
  - On release, the next window (byte24=0x45) follows with no loss or duplication.
- Reset mid-frame after 20 pixels, then a fresh frame: no window_valid until pixel (4,4) of the new frame; window contents are correct.
- pixel_first asserted at stale counter position (3,2):
  - Counters resync.
  - The window for (4,4) of the new frame is correct.
  - No window is emitted before it.
- Random pixel_valid gaps (≈50% duty): window sequence is identical to the continuous run.
- WINDOW_STATUS_EN defined:
  - First window has window_x=2, window_y=2.
  - frame_done pulses exactly once, one cycle after accept of (7,5).
